escalonador_paradas: RTL

- Floor-call scheduler for the 4-floor cargo lift.
- Collects floor requests from the serial/UART front end into a pending-call bitmap.
- Chooses the next stop with a SCAN (keep-direction) policy and drives the motor-up/motor-down commands.
- Runs a timed stop (dwell) at each served floor. It sits between the request sources and the motion datapath, replacing ad-hoc queue sequencing.

---
 rtl/escalonador_paradas.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/escalonador_paradas.sv
// Floor-call scheduler for the cargo lift: pending-call bitmap, SCAN (keep-direction)
// stop selection, motor commands and a timed dwell at each served floor.
module escalonador_paradas #(
    parameter  int unsigned N_ANDARES = 4,
    parameter  int unsigned T_PARADA  = 100000000,
    localparam int unsigned AW        = $clog2(N_ANDARES)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valido,
    input  logic [AW-1:0]        req_andar,
    output logic                 req_aceito,
    input  logic [AW-1:0]        andarAtual,
    input  logic                 sensor_valido,
    input  logic                 emergencia,
    output logic [AW-1:0]        proxParada,
    output logic                 temDestino,
    output logic                 motorSubindo,
    output logic                 motorDescendo,
    output logic                 porta_aberta,
    output logic                 sentido,
    output logic [N_ANDARES-1:0] pendentes,
    output logic [3:0]           estado_db
);

    localparam int unsigned TW = (T_PARADA > 1) ? $clog2(T_PARADA) : 1;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        DECIDE   = 3'd1,
        SUBINDO  = 3'd2,
        DESCENDO = 3'd3,
        PARADO   = 3'd4,
        EMERG    = 3'd5
    } estado_t;

    estado_t               estado;
    logic [AW-1:0]         andar_reg;
    logic [TW-1:0]         timer;
    logic [N_ANDARES-1:0]  pend_d;
    logic [AW-1:0]         acima, abaixo, alvo, andar_limite;
    logic                  tem_acima, tem_abaixo, inverte, reinicia;

    // Nearest pending floor at/above and at/below the last sensed floor.
    always_comb begin
        tem_acima  = 1'b0;
        acima      = '0;
        tem_abaixo = 1'b0;
        abaixo     = '0;
        for (int i = int'(N_ANDARES) - 1; i >= 0; i--) begin
            if (pendentes[AW'(i)] && (AW'(i) >= andar_reg)) begin
                tem_acima = 1'b1;
                acima     = AW'(i);
            end
        end
        for (int i = 0; i < int'(N_ANDARES); i++) begin
            if (pendentes[AW'(i)] && (AW'(i) <= andar_reg)) begin
                tem_abaixo = 1'b1;
                abaixo     = AW'(i);
            end
        end
    end

    // SCAN choice: keep direction while calls remain ahead, otherwise turn around.
    always_comb begin
        alvo    = proxParada;
        inverte = 1'b0;
        if (sentido) begin
            if (tem_acima) begin
                alvo = acima;
            end else if (tem_abaixo) begin
                alvo    = abaixo;
                inverte = 1'b1;
            end
        end else begin
            if (tem_abaixo) begin
                alvo = abaixo;
            end else if (tem_acima) begin
                alvo    = acima;
                inverte = 1'b1;
            end
        end
    end

    // Request merge; a call for the floor we are parked at only extends the dwell.
    always_comb begin
        reinicia = (estado == PARADO) && req_valido && (req_andar == andar_reg);
        pend_d   = pendentes;
        if (req_valido && !reinicia) begin
            pend_d[req_andar] = 1'b1;
        end
    end

    assign andar_limite = (estado == SUBINDO) ? AW'(N_ANDARES - 1) : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado     <= OCIOSO;
            pendentes  <= '0;
            proxParada <= '0;
            sentido    <= 1'b1;
            req_aceito <= 1'b0;
            timer      <= '0;
            andar_reg  <= '0;
        end else begin
            req_aceito <= req_valido;
            pendentes  <= pend_d;
            if (sensor_valido) begin
                andar_reg <= andarAtual;
            end
            if (emergencia) begin
                estado <= EMERG;
                timer  <= '0;
            end else begin
                case (estado)
                    OCIOSO: begin
                        if (|pendentes) estado <= DECIDE;
                    end
                    DECIDE: begin
                        proxParada <= alvo;
                        if (pendentes == '0) begin
                            estado <= OCIOSO;
                        end else begin
                            if (inverte) sentido <= ~sentido;
                            if (alvo == andar_reg) begin
                                estado    <= PARADO;
                                pendentes <= pend_d & ~(N_ANDARES'(1) << alvo);
                                timer     <= '0;
                            end else if (alvo > andar_reg) begin
                                estado <= SUBINDO;
                            end else begin
                                estado <= DESCENDO;
                            end
                        end
                    end
                    SUBINDO, DESCENDO: begin
                        proxParada <= alvo;
                        if (sensor_valido && (andarAtual == proxParada)) begin
                            estado    <= PARADO;
                            pendentes <= pend_d & ~(N_ANDARES'(1) << andarAtual);
                            timer     <= '0;
                        end else if (sensor_valido && (andarAtual == andar_limite)) begin
                            // end of shaft reached without a matching call
                            estado <= DECIDE;
                        end
                    end
                    PARADO: begin
                        if (reinicia) begin
                            timer <= '0;
                        end else if (timer == TW'(T_PARADA - 1)) begin
                            timer  <= '0;
                            estado <= (|pendentes) ? DECIDE : OCIOSO;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    EMERG: begin
                        estado <= (|pendentes) ? DECIDE : OCIOSO;
                    end
                    default: begin
                        estado <= OCIOSO;
                    end
                endcase
            end
        end
    end

    assign motorSubindo  = (estado == SUBINDO);
    assign motorDescendo = (estado == DESCENDO);
    assign porta_aberta  = (estado == PARADO);
    assign temDestino    = |pendentes;
    assign estado_db     = 4'(estado);

endmodule
